// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel 3x3 window generator: default geometry,
// pixel width, the line-fill state encoding and the state-advance helper.
package sobel_pkg;

    localparam int DEF_PIX_W      = 8;
    localparam int DEF_IMG_WIDTH  = 640;
    localparam int DEF_IMG_HEIGHT = 480;

    // Line-fill states: two priming lines, then lines that produce windows.
    localparam logic [1:0] FILL0  = 2'd0;
    localparam logic [1:0] FILL1  = 2'd1;
    localparam logic [1:0] ACTIVE = 2'd2;

    // State to enter at the end of a line; the last line of the frame
    // returns the machine to FILL0 for the next frame.
    function automatic logic [1:0] line_end_state(input logic [1:0] state,
                                                  input logic       frame_end);
        logic [1:0] nxt;
        case (state)
            FILL0:   nxt = FILL1;
            FILL1:   nxt = ACTIVE;
            ACTIVE:  nxt = frame_end ? FILL0 : ACTIVE;
            default: nxt = FILL0;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// One line of pixel storage. Single port: the old word at addr is visible
// combinationally during the cycle in which the new word is written, so
// the caller sees read-before-write data. Contents are never cleared.
module sobel_line_buffer
    import sobel_pkg::*;
#(
    parameter int DEPTH  = DEF_IMG_WIDTH,
    parameter int DATA_W = DEF_PIX_W,
    parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_r [DEPTH];

    assign rdata = mem_r[addr];

    // Store the incoming word; the read above still returns the previous one.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end
    end

endmodule

// File: rtl/sobel_window_gen.sv
// Streaming 3x3 neighbourhood generator feeding the Sobel gradient stage.
// Pixels arrive in raster order; two line buffers hold lines r-1 and r-2,
// and a 3x3 shift window is presented with a one-cycle done_o strobe for
// every interior position (no padded border windows).
// Optional build macro SOBEL_WINDOW_SOF_EN adds sof_i, which forces the
// accompanying pixel to row 0 / column 0 and restarts line filling.
module sobel_window_gen
    import sobel_pkg::*;
#(
    parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
    parameter int PIX_W      = DEF_PIX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PIX_W-1:0] pixel_i,
    input  logic             valid_i,
`ifdef SOBEL_WINDOW_SOF_EN
    input  logic             sof_i,
`endif
    output logic [PIX_W-1:0] d0_o,
    output logic [PIX_W-1:0] d1_o,
    output logic [PIX_W-1:0] d2_o,
    output logic [PIX_W-1:0] d3_o,
    output logic [PIX_W-1:0] d4_o,
    output logic [PIX_W-1:0] d5_o,
    output logic [PIX_W-1:0] d6_o,
    output logic [PIX_W-1:0] d7_o,
    output logic [PIX_W-1:0] d8_o,
    output logic             done_o,
    output logic             eof_o
);

    localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

    localparam logic [CW-1:0] COL_LAST  = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_HEIGHT - 1);
    // First column whose window lies entirely within the current line.
    localparam logic [CW-1:0] COL_WIN0  = CW'(2);

    logic [CW-1:0]    col_r, col_cur_s, col_nxt_s;
    logic [RW-1:0]    row_r, row_cur_s, row_nxt_s;
    logic [1:0]       state_r, state_cur_s, state_nxt_s;
    logic             line_end_s, frame_end_s;
    logic             done_nxt_s, eof_nxt_s;
    logic             done_r, eof_r;
    logic [PIX_W-1:0] lb0_rd_s, lb1_rd_s;
    logic [PIX_W-1:0] d0_r, d1_r, d2_r, d3_r, d4_r, d5_r, d6_r, d7_r, d8_r;

    // Position this pixel is treated as having (sof_i overrides the counters).
    always_comb begin
        col_cur_s   = col_r;
        row_cur_s   = row_r;
        state_cur_s = state_r;
`ifdef SOBEL_WINDOW_SOF_EN
        if (valid_i && sof_i) begin
            col_cur_s   = {CW{1'b0}};
            row_cur_s   = {RW{1'b0}};
            state_cur_s = FILL0;
        end else begin
            col_cur_s   = col_r;
            row_cur_s   = row_r;
            state_cur_s = state_r;
        end
`endif
        line_end_s  = (col_cur_s == COL_LAST);
        frame_end_s = line_end_s && (row_cur_s == ROW_LAST);
    end

    // Counter / state advance and the strobes that accompany this pixel.
    always_comb begin
        col_nxt_s   = col_r;
        row_nxt_s   = row_r;
        state_nxt_s = state_r;
        if (valid_i) begin
            if (line_end_s) begin
                col_nxt_s   = {CW{1'b0}};
                state_nxt_s = line_end_state(state_cur_s, frame_end_s);
                if (frame_end_s) begin
                    row_nxt_s = {RW{1'b0}};
                end else begin
                    row_nxt_s = row_cur_s + RW'(1);
                end
            end else begin
                col_nxt_s   = col_cur_s + CW'(1);
                row_nxt_s   = row_cur_s;
                state_nxt_s = state_cur_s;
            end
        end else begin
            col_nxt_s   = col_r;
            row_nxt_s   = row_r;
            state_nxt_s = state_r;
        end
        done_nxt_s = valid_i && (state_cur_s == ACTIVE) && (col_cur_s >= COL_WIN0);
        eof_nxt_s  = valid_i && (state_cur_s == ACTIVE) && frame_end_s;
    end

    // lb0 holds line r-1: it takes the incoming pixel.
    sobel_line_buffer #(
        .DEPTH  (IMG_WIDTH),
        .DATA_W (PIX_W),
        .ADDR_W (CW)
    ) u_lb0 (
        .clk   (clk),
        .we    (valid_i),
        .addr  (col_cur_s),
        .wdata (pixel_i),
        .rdata (lb0_rd_s)
    );

    // lb1 holds line r-2: it takes what lb0 held at the same column.
    sobel_line_buffer #(
        .DEPTH  (IMG_WIDTH),
        .DATA_W (PIX_W),
        .ADDR_W (CW)
    ) u_lb1 (
        .clk   (clk),
        .we    (valid_i),
        .addr  (col_cur_s),
        .wdata (lb0_rd_s),
        .rdata (lb1_rd_s)
    );

    // Frame position, fill state and output strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_r   <= {CW{1'b0}};
            row_r   <= {RW{1'b0}};
            state_r <= FILL0;
            done_r  <= 1'b0;
            eof_r   <= 1'b0;
        end else begin
            col_r   <= col_nxt_s;
            row_r   <= row_nxt_s;
            state_r <= state_nxt_s;
            done_r  <= done_nxt_s;
            eof_r   <= eof_nxt_s;
        end
    end

    // 3x3 window: shift left on every accepted pixel, hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            d0_r <= {PIX_W{1'b0}};
            d1_r <= {PIX_W{1'b0}};
            d2_r <= {PIX_W{1'b0}};
            d3_r <= {PIX_W{1'b0}};
            d4_r <= {PIX_W{1'b0}};
            d5_r <= {PIX_W{1'b0}};
            d6_r <= {PIX_W{1'b0}};
            d7_r <= {PIX_W{1'b0}};
            d8_r <= {PIX_W{1'b0}};
        end else if (valid_i) begin
            d0_r <= d1_r;
            d1_r <= d2_r;
            d2_r <= lb1_rd_s;
            d3_r <= d4_r;
            d4_r <= d5_r;
            d5_r <= lb0_rd_s;
            d6_r <= d7_r;
            d7_r <= d8_r;
            d8_r <= pixel_i;
        end
    end

    assign d0_o   = d0_r;
    assign d1_o   = d1_r;
    assign d2_o   = d2_r;
    assign d3_o   = d3_r;
    assign d4_o   = d4_r;
    assign d5_o   = d5_r;
    assign d6_o   = d6_r;
    assign d7_o   = d7_r;
    assign d8_o   = d8_r;
    assign done_o = done_r;
    assign eof_o  = eof_r;

endmodule

// File: doc/sobel_window_gen.md
Name: sobel_window_gen

Overview:
- Streaming 3x3 neighbourhood generator; sits directly upstream of the Sobel gradient stage.
- Accepts one 8-bit grayscale pixel per valid cycle in raster order and buffers two previous lines.
- Presents the full 3x3 window on d0_o..d8_o with a one-cycle done_o strobe per valid window.
- Outputs map 1:1 onto the Sobel stage's d0_i..d8_i and done_i.

Parameters:
- IMG_WIDTH, 640, pixels per line (>= 3)
- IMG_HEIGHT, 480, lines per frame (>= 3)
- PIX_W, 8, pixel width in bits

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- pixel_i  in  PIX_W  input pixel, raster order
- valid_i  in  1  pixel_i is valid this cycle; gaps allowed anywhere
- d0_o..d8_o  out  PIX_W each  window, row-major: d0 d1 d2 = top row (line r-2), d3 d4 d5 = middle row (r-1), d6 d7 d8 = bottom row (r); d0/d3/d6 = leftmost column (c-2), d8 = newest pixel
- done_o  out  1  window valid, one-cycle pulse
- eof_o  out  1  pulses together with done_o for the last window of the frame

Behaviour:
- Reset: d0_o..d8_o = 0, done_o = 0, eof_o = 0, col/row counters = 0, state = FILL0. Line-buffer RAM is not cleared; row gating makes stale contents harmless.
- Counters:
  - col counts 0..IMG_WIDTH-1; row counts 0..IMG_HEIGHT-1; both advance only on valid_i.
  - col wraps to 0 and row increments at end of line.
  - After the last pixel (row = IMG_HEIGHT-1, col = IMG_WIDTH-1), both wrap to 0 and state returns to FILL0.
- State machine (advances at line end):
  - FILL0: line 0. Goes to FILL1.
  - FILL1: line 1. Goes to ACTIVE.
  - ACTIVE: lines 2..H-1. Goes to FILL0 after the last frame pixel.
- Line buffers:
  - lb0 holds line r-1; lb1 holds line r-2; each is IMG_WIDTH deep.
  - On each valid_i at column col: read lb0[col] and lb1[col] (old data), write lb0[col] <= pixel_i and lb1[col] <= old lb0[col].
  - Read-before-write semantics are required.
- Window shift, on valid_i only:
  - d0<=d1, d1<=d2, d2<=lb1[col]
  - d3<=d4, d4<=d5, d5<=lb0[col]
  - d6<=d7, d7<=d8, d8<=pixel_i
- Hold: when valid_i = 0, the window registers hold and done_o = 0.
- done_o: registered (valid_i && state==ACTIVE && col>=2). Latency is 1 cycle from the accepted pixel; done_o is coincident with the updated window.
- Output count: (IMG_WIDTH-2)*(IMG_HEIGHT-2) done_o pulses per frame. No border/padded windows are produced.
- Line wrap: a window never straddles lines, because col>=2 gating discards the first two shifts of each line.
- Back-to-back frames: the first pixel of frame N+1 may follow the last of frame N with no gap.
- Reset mid-frame: all counters and outputs return to reset values the next cycle; a partial frame is discarded.

Optional Feature:
- Macro: SOBEL_WINDOW_SOF_EN.
- Defined:
  - Adds input port sof_i (1 bit).
  - valid_i && sof_i forces that pixel to col = 0, row = 0, state FILL0, overriding counter position. Resyncs after dropped or extra pixels.
  - A pending partial frame produces no further done_o.
  - eof_o is unchanged.
- Undefined: no sof_i port; framing relies solely on counters from reset.

Decomposition:
- Shared package sobel_pkg: PIX_W, default IMG_WIDTH/IMG_HEIGHT, state enum {FILL0, FILL1, ACTIVE}.
- One sub-module: sobel_line_buffer. Single-port, IMG_WIDTH x PIX_W, read-before-write, write enable = valid_i. Instantiated twice.

Test Plan (IMG_WIDTH=4, IMG_HEIGHT=4, pixel = row*16+col):
- Continuous 16-pixel frame -> exactly 4 done_o pulses.
  - First (after input 0x22): d0..d8 = 00,01,02,10,11,12,20,21,22.
  - Last: 11,12,13,21,22,23,31,32,33 with eof_o = 1.
- Same frame with valid_i deasserted every other cycle -> identical window values; done_o never asserted while valid_i was low on the prior cycle.
- Two frames back-to-back, frame 2 = frame 1 + 0x80 -> 8 pulses; frame 2's first window = 80,81,82,90,91,92,A0,A1,A2 (no frame-1 data).
- rst asserted after 10 pixels, then full frame -> outputs 0 during reset; then exactly 4 correct windows.
- With SOBEL_WINDOW_SOF_EN: 6 garbage pixels, then sof_i with pixel 0x00 and full frame -> first window equals scenario 1.
- Chained with the Sobel stage, flat 0x80 image -> all grayscale outputs 0; vertical step 0x00 | 0xFF at col 2 -> 255.
